// File: rtl/divider_controller_if.sv
// ---------------------------------------------------------------------------
// divider_controller_if
//   Configuration handshake between a CSR block (master) and the
//   divider_controller (slave). A request is transferred on any rising edge
//   where cfg_valid and cfg_ready are both high.
//
//   cfg_valid    master -> slave  request valid
//   cfg_ready    slave  -> master controller can accept a request this cycle
//   cfg_divider  master -> slave  requested divide ratio D (BITS wide)
//   cfg_enable   master -> slave  1 = run at cfg_divider, 0 = stop at boundary
//   cfg_error    slave  -> master one-cycle pulse: accepted request had D < 2
// ---------------------------------------------------------------------------
interface divider_controller_if #(
    parameter int BITS = 8
);
    logic            cfg_valid;
    logic            cfg_ready;
    logic [BITS-1:0] cfg_divider;
    logic            cfg_enable;
    logic            cfg_error;

    modport master (
        output cfg_valid,
        output cfg_divider,
        output cfg_enable,
        input  cfg_ready,
        input  cfg_error
    );

    modport slave (
        input  cfg_valid,
        input  cfg_divider,
        input  cfg_enable,
        output cfg_ready,
        output cfg_error
    );
endinterface

// File: rtl/divider_controller.sv
// ---------------------------------------------------------------------------
// divider_controller
//   Runtime-programmable clock divider. Produces a divided clock level and a
//   one-cycle period-end tick from InputCLK. New ratios and start/stop
//   requests are only applied at a period boundary, so OutputCLK never shows
//   a runt pulse.
//
//   Parameters
//     DIV_DEFAULT    ratio loaded at reset (>= 2)
//     BITS           width of the period counter and of cfg_divider
//     START_ENABLED  1: leave reset dividing at DIV_DEFAULT, 0: leave reset idle
//
//   Ports
//     InputCLK   in   single clock, all logic on its rising edge
//     rst        in   synchronous active-high reset
//     cfg        slave modport of divider_controller_if (valid/ready config)
//     OutputCLK  out  divided clock level, registered
//     tick       out  one-cycle pulse coincident with each OutputCLK fall
//     running    out  1 while dividing (including with a request pending)
// ---------------------------------------------------------------------------
module divider_controller #(
    parameter int DIV_DEFAULT   = 10,
    parameter int BITS          = 8,
    parameter int START_ENABLED = 0
) (
    input  logic                   InputCLK,
    input  logic                   rst,
    divider_controller_if.slave    cfg,
    output logic                   OutputCLK,
    output logic                   tick,
    output logic                   running
);

    localparam logic [BITS-1:0] DIV_INIT = BITS'(DIV_DEFAULT);
    localparam logic [BITS-1:0] DIV_MIN  = BITS'(2);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_PENDING = 2'd2
    } state_t;

    localparam state_t RESET_STATE = (START_ENABLED != 0) ? S_RUN : S_IDLE;

    // Registered state
    state_t          state_q;
    logic [BITS-1:0] count_q;
    logic [BITS-1:0] div_q;
    logic            clk_q;
    logic            tick_q;
    logic            err_q;
    logic [BITS-1:0] pend_div_q;
    logic            pend_en_q;

    // Next-state values
    state_t          state_d;
    logic [BITS-1:0] count_d;
    logic [BITS-1:0] div_d;
    logic            clk_d;
    logic            tick_d;
    logic            err_d;
    logic            pend_load;

    logic            ready;
    logic            xfer;
    logic            cfg_bad;
    logic [BITS-1:0] rise_cnt;
    logic [BITS-1:0] last_cnt;
    logic            at_rise;
    logic            at_last;

    // Only a held request blocks new ones; the CSR side can stall on PENDING.
    assign ready   = (state_q != S_PENDING);
    assign xfer    = cfg.cfg_valid & ready;

    // A ratio below 2 is only an error when it asks to run; with enable=0
    // the divider field is ignored and the request is a legal stop.
    assign cfg_bad = cfg.cfg_enable & (cfg.cfg_divider < DIV_MIN);

    // div_q >= 2 always holds, so neither subtraction can underflow.
    assign rise_cnt = (div_q >> 1) - 1'b1;
    assign last_cnt = div_q - 1'b1;
    assign at_rise  = (count_q == rise_cnt);
    assign at_last  = (count_q == last_cnt);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        div_d     = div_q;
        clk_d     = clk_q;
        tick_d    = 1'b0;
        err_d     = xfer & cfg_bad;
        pend_load = 1'b0;

        case (state_q)
            S_IDLE: begin
                count_d = '0;
                clk_d   = 1'b0;
                // enable=0 from IDLE is accepted and dropped.
                if (xfer && cfg.cfg_enable && !cfg_bad) begin
                    div_d   = cfg.cfg_divider;
                    state_d = S_RUN;
                end
            end

            S_RUN, S_PENDING: begin
                if (at_last) begin
                    // Period boundary: the only point where D or the run
                    // state may change.
                    count_d = '0;
                    clk_d   = 1'b0;
                    tick_d  = 1'b1;
                    if (state_q == S_PENDING) begin
                        if (pend_en_q) begin
                            div_d   = pend_div_q;
                            state_d = S_RUN;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end else begin
                    count_d = count_q + 1'b1;
                    if (at_rise) begin
                        clk_d = 1'b1;
                    end
                end

                // A request landing on the boundary edge still waits for
                // the following boundary: the current edge uses old D.
                if (state_q == S_RUN && xfer && !cfg_bad) begin
                    pend_load = 1'b1;
                    state_d   = S_PENDING;
                end
            end

            default: begin
                state_d = S_IDLE;
                count_d = '0;
                clk_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge InputCLK) begin
        if (rst) begin
            state_q <= RESET_STATE;
            count_q <= '0;
            div_q   <= DIV_INIT;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            div_q   <= div_d;
            clk_q   <= clk_d;
            tick_q  <= tick_d;
            err_q   <= err_d;
        end
    end

    // Held request payload: only read while in PENDING, which is entered on
    // the same edge it is loaded, so it needs no reset.
    always_ff @(posedge InputCLK) begin
        if (pend_load) begin
            pend_div_q <= cfg.cfg_divider;
            pend_en_q  <= cfg.cfg_enable;
        end
    end

    assign cfg.cfg_ready = ready;
    assign cfg.cfg_error = err_q;
    assign OutputCLK     = clk_q;
    assign tick          = tick_q;
    assign running       = (state_q != S_IDLE);

endmodule

// File: tb/tb_divider_controller.sv
module tb_divider_controller;

    localparam int BITS    = 8;
    localparam int DIV_DEF = 10;
    localparam int START   = 0;

    logic InputCLK = 1'b0;
    logic rst      = 1'b1;
    logic OutputCLK, tick, running;

    always #5 InputCLK = ~InputCLK;

    divider_controller_if #(.BITS(BITS)) cfg_if ();

    divider_controller #(
        .DIV_DEFAULT  (DIV_DEF),
        .BITS         (BITS),
        .START_ENABLED(START)
    ) dut (
        .InputCLK (InputCLK),
        .rst      (rst),
        .cfg      (cfg_if),
        .OutputCLK(OutputCLK),
        .tick     (tick),
        .running  (running)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A period is a run of D cycles indexed by position 0..D-1; the clock is
    // high for positions >= D/2, the tick marks the first cycle after a
    // period completes. Requests are applied when a period completes.
    bit m_act  = 0;
    int m_pos  = 0;
    int m_D    = DIV_DEF;
    bit m_pend = 0;
    int m_pD   = 0;
    bit m_pen  = 0;
    bit e_tick = 0;
    bit e_err  = 0;

    initial begin
        forever begin
            @(posedge InputCLK);
            begin
                bit xfer, en, was_act, bad;
                int dv;
                xfer = cfg_if.cfg_valid && !m_pend;
                en   = cfg_if.cfg_enable;
                dv   = int'(cfg_if.cfg_divider);
                bad  = en && (dv < 2);
                if (rst) begin
                    m_act = (START != 0); m_pos = 0; m_D = DIV_DEF;
                    m_pend = 0; e_tick = 0; e_err = 0;
                end else begin
                    was_act = m_act;
                    e_tick  = m_act && (m_pos == m_D - 1);
                    e_err   = xfer && bad;
                    if (m_act) begin
                        if (m_pos == m_D - 1) begin
                            m_pos = 0;
                            if (m_pend) begin
                                if (m_pen) m_D = m_pD;
                                else       m_act = 0;
                                m_pend = 0;
                            end
                        end else begin
                            m_pos++;
                        end
                    end
                    if (xfer && !bad) begin
                        if (!was_act) begin
                            if (en) begin m_D = dv; m_act = 1; m_pos = 0; end
                        end else begin
                            m_pend = 1; m_pD = dv; m_pen = en;
                        end
                    end
                end
            end
            @(negedge InputCLK);
            check("OutputCLK", OutputCLK, (m_act && m_pos >= m_D / 2) ? 1 : 0);
            check("tick", tick, e_tick);
            check("running", running, m_act);
            check("cfg_ready", cfg_if.cfg_ready, !m_pend);
            check("cfg_error", cfg_if.cfg_error, e_err);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input int dv, input bit en);
        bit ok;
        ok = 0;
        cfg_if.cfg_valid   = 1'b1;
        cfg_if.cfg_divider = dv[BITS-1:0];
        cfg_if.cfg_enable  = en;
        for (int i = 0; i < 600; i++) begin
            if (cfg_if.cfg_ready) begin ok = 1; break; end
            @(negedge InputCLK);
        end
        check("send_ready_timeout", ok, 1);
        @(negedge InputCLK);
        cfg_if.cfg_valid = 1'b0;
    endtask

    // Advance to the next cycle with tick high; n = negedges advanced.
    task automatic wait_tick(output int n);
        bit ok;
        ok = 0;
        n  = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge InputCLK);
            n++;
            if (tick) begin ok = 1; break; end
        end
        check("tick_timeout", ok, 1);
    endtask

    // From a tick cycle, measure length and high cycles of the period starting here.
    task automatic measure_here(output int per, output int hi);
        per = 0;
        hi  = 0;
        for (int i = 0; i < 600; i++) begin
            hi += int'(OutputCLK);
            per++;
            @(negedge InputCLK);
            if (tick) break;
        end
    endtask

    task automatic measure(output int per, output int hi);
        int n;
        wait_tick(n);
        measure_here(per, hi);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int per, hi, n, ticks;
        bit seen;
        cfg_if.cfg_valid   = 1'b0;
        cfg_if.cfg_divider = '0;
        cfg_if.cfg_enable  = 1'b0;

        // Reset state
        repeat (2) @(posedge InputCLK);
        @(negedge InputCLK);
        check("rst_OutputCLK", OutputCLK, 0);
        check("rst_tick", tick, 0);
        check("rst_running", running, 0);
        check("rst_cfg_ready", cfg_if.cfg_ready, 1);
        rst = 1'b0;
        @(negedge InputCLK);

        // Start at D=10 from IDLE
        send(10, 1);
        check("run_running", running, 1);
        measure(per, hi);
        check("d10_period", per, 10);
        check("d10_high", hi, 5);

        // Reconfigure to D=4 at count 3: current period stays 10
        repeat (3) @(negedge InputCLK);
        send(4, 1);
        check("pending_ready", cfg_if.cfg_ready, 0);
        wait_tick(n);
        check("old_period_kept", n + 4, 10);
        measure_here(per, hi);
        check("d4_period", per, 4);
        check("d4_high", hi, 2);

        // D=1 with enable -> error pulse, ratio unchanged
        send(1, 1);
        check("err_pulse", cfg_if.cfg_error, 1);
        @(negedge InputCLK);
        check("err_one_cycle", cfg_if.cfg_error, 0);
        measure(per, hi);
        check("after_err_period", per, 4);

        // D=3 -> 1 low / 2 high
        send(3, 1);
        measure(per, hi);
        check("d3_period", per, 3);
        check("d3_high", hi, 2);

        // Stop request (D=0, enable=0 is legal)
        send(0, 0);
        check("stop_no_err", cfg_if.cfg_error, 0);
        wait_tick(n);
        check("stop_running", running, 0);
        check("stop_OutputCLK", OutputCLK, 0);
        ticks = 0;
        repeat (20) begin
            @(negedge InputCLK);
            ticks += int'(tick);
        end
        check("idle_no_ticks", ticks, 0);

        // Reset mid-period while OutputCLK is high
        send(10, 1);
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            if (OutputCLK) begin seen = 1; break; end
            @(negedge InputCLK);
        end
        check("saw_high_before_rst", seen, 1);
        rst = 1'b1;
        @(negedge InputCLK);
        rst = 1'b0;
        check("midrst_OutputCLK", OutputCLK, 0);
        check("midrst_tick", tick, 0);
        check("midrst_running", running, 0);
        check("midrst_ready", cfg_if.cfg_ready, 1);

        // Smallest and largest ratios
        send(2, 1);
        measure(per, hi);
        check("d2_period", per, 2);
        check("d2_high", hi, 1);
        send(255, 1);
        measure(per, hi);
        check("d255_period", per, 255);
        check("d255_high", hi, 128);

        // Randomized traffic checked by the model every cycle
        for (int c = 0; c < 4000; c++) begin
            int r;
            @(negedge InputCLK);
            r = $urandom_range(0, 19);
            cfg_if.cfg_valid   = ($urandom_range(0, 3) == 0);
            cfg_if.cfg_enable  = ($urandom_range(0, 4) != 0);
            if (r < 16)      cfg_if.cfg_divider = BITS'($urandom_range(0, 12));
            else if (r < 18) cfg_if.cfg_divider = 8'd255;
            else             cfg_if.cfg_divider = BITS'($urandom_range(0, 255));
            rst = ($urandom_range(0, 499) == 0);
        end
        @(negedge InputCLK);
        cfg_if.cfg_valid = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge InputCLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
